// File: rtl/led_pio_pwm.sv
// -----------------------------------------------------------------------------
// led_pio_pwm
//   Avalon-MM LED controller. Each of WIDTH channels is either a static bit
//   (DATA) or a PWM channel with its own duty register. A shared prescaler
//   clocks a PWM_BITS-wide period counter. Duty writes are held as "pending"
//   values and are copied to the active registers on the period wrap, so a
//   running period is never cut short or stretched.
//
//   Optional feature macro: LED_PIO_BLINK_EN
//     Adds the BLINK register at word 6 and a blink phase that toggles every
//     2^BLINK_SHIFT period wraps. Without it, word 6 reads 0 and ignores writes.
//
// Ports
//   clk_clk          system clock (single domain)
//   reset_reset      synchronous, active-high reset
//   avs_address      word address (0 DATA, 1 MODE, 2 PRESCALE, 3 DUTY_SEL,
//                    4 DUTY, 5 CTRL, 6 BLINK)
//   avs_read         read strobe; avs_readdata valid one cycle later
//   avs_write        write strobe
//   avs_writedata    write data
//   avs_readdata     registered read data, held until the next read
//   led_pio_export   registered LED outputs
//   irq              registered level interrupt (IRQ_PEND & IRQ_EN)
// -----------------------------------------------------------------------------
module led_pio_pwm #(
    parameter int WIDTH       = 8,
    parameter int PWM_BITS    = 8,
    parameter int BLINK_SHIFT = 6
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic [WIDTH-1:0] led_pio_export,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_DUTY_SEL = 3'd3;
    localparam logic [2:0] ADDR_DUTY     = 3'd4;
    localparam logic [2:0] ADDR_CTRL     = 3'd5;
    localparam logic [2:0] ADDR_BLINK    = 3'd6;

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    mode_q;
    logic [15:0]         prescale_q;
    logic [15:0]         pre_q;
    logic [4:0]          duty_sel_q;
    logic                enable_q;
    logic                invert_q;
    logic                irq_en_q;
    logic                irq_pend_q;
    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_pend_q [WIDTH];
    logic [PWM_BITS-1:0] duty_act_q  [WIDTH];

    logic                tick;
    logic                boundary;
    logic [WIDTH-1:0]    raw;
    logic [WIDTH-1:0]    visible;
    logic [31:0]         rd_mux;
    logic                wr_data, wr_mode, wr_prescale, wr_duty_sel, wr_duty, wr_ctrl;

    // Write-data bits beyond the widest register are intentionally ignored.
    logic                unused_wdata;
    assign unused_wdata = ^avs_writedata;

    assign wr_data     = avs_write && (avs_address == ADDR_DATA);
    assign wr_mode     = avs_write && (avs_address == ADDR_MODE);
    assign wr_prescale = avs_write && (avs_address == ADDR_PRESCALE);
    assign wr_duty_sel = avs_write && (avs_address == ADDR_DUTY_SEL);
    assign wr_duty     = avs_write && (avs_address == ADDR_DUTY);
    assign wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);

    // Counters are held at 0 while disabled, so tick can only fire when enabled.
    assign tick     = enable_q && (pre_q == prescale_q);
    // The wrapping tick is the period boundary.
    assign boundary = tick && (cnt_q == {PWM_BITS{1'b1}});

    // Control registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            data_q     <= '0;
            mode_q     <= '0;
            prescale_q <= '0;
            duty_sel_q <= '0;
            enable_q   <= 1'b0;
            invert_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            if (wr_data)     data_q     <= avs_writedata[WIDTH-1:0];
            if (wr_mode)     mode_q     <= avs_writedata[WIDTH-1:0];
            if (wr_prescale) prescale_q <= avs_writedata[15:0];
            if (wr_duty_sel) duty_sel_q <= avs_writedata[4:0];
            if (wr_ctrl) begin
                enable_q <= avs_writedata[0];
                invert_q <= avs_writedata[1];
                irq_en_q <= avs_writedata[2];
            end
            // A boundary in the same cycle as a write-1-to-clear keeps the flag set.
            if (boundary)
                irq_pend_q <= 1'b1;
            else if (wr_ctrl && avs_writedata[3])
                irq_pend_q <= 1'b0;
        end
    end

    // Pending / active duty registers. A DUTY_SEL outside 0..WIDTH-1 matches no
    // channel, so such writes fall away naturally.
    // NOTE: the duty arrays are reset on purpose: outputs must come up dark and
    // the first period after reset must run with duty 0.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                duty_pend_q[i] <= '0;
                duty_act_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (boundary)
                    duty_act_q[i] <= duty_pend_q[i];
                if (wr_duty && (duty_sel_q == 5'(i)))
                    duty_pend_q[i] <= avs_writedata[PWM_BITS-1:0];
            end
        end
    end

    // Prescaler and PWM period counter.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            if (!enable_q) begin
                pre_q <= '0;
                cnt_q <= '0;
            end else if (tick) begin
                pre_q <= '0;
                cnt_q <= cnt_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            // Restart the prescale interval so the new value applies immediately.
            if (wr_prescale)
                pre_q <= '0;
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]     blink_q;
    logic [BLINK_SHIFT:0] blink_cnt_q;

    // The MSB of the boundary counter is the blink phase; 1 = visible.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            blink_q     <= '0;
            blink_cnt_q <= '0;
        end else begin
            if (avs_write && (avs_address == ADDR_BLINK))
                blink_q <= avs_writedata[WIDTH-1:0];
            if (!enable_q)
                blink_cnt_q <= '0;
            else if (boundary)
                blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign visible = ~(blink_q & {WIDTH{~blink_cnt_q[BLINK_SHIFT]}});
`else
    localparam int BLINK_SHIFT_UNUSED = BLINK_SHIFT;
    assign visible = '1;
`endif

    // Raw per-channel level before blink gating and inversion.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        raw = '0;
        for (int i = 0; i < WIDTH; i++)
            raw[i] = mode_q[i] ? (cnt_q < duty_act_q[i]) : data_q[i];
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = data_q;
            ADDR_MODE:     rd_mux[WIDTH-1:0] = mode_q;
            ADDR_PRESCALE: rd_mux[15:0]      = prescale_q;
            ADDR_DUTY_SEL: rd_mux[4:0]       = duty_sel_q;
            ADDR_DUTY: begin
                for (int i = 0; i < WIDTH; i++)
                    if (duty_sel_q == 5'(i))
                        rd_mux[PWM_BITS-1:0] = duty_pend_q[i];
            end
            ADDR_CTRL:     rd_mux[3:0] = {irq_pend_q, irq_en_q, invert_q, enable_q};
`ifdef LED_PIO_BLINK_EN
            ADDR_BLINK:    rd_mux[WIDTH-1:0] = blink_q;
`endif
            default:       rd_mux = '0;
        endcase
    end

    // Registered outputs. Read data is sampled before any same-cycle write
    // lands, so a simultaneous read and write returns the old value.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            led_pio_export <= '0;
            irq            <= 1'b0;
            avs_readdata   <= '0;
        end else begin
            led_pio_export <= enable_q ? ((raw & visible) ^ {WIDTH{invert_q}}) : '0;
            irq            <= irq_pend_q & irq_en_q;
            if (avs_read)
                avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_led_pio_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_pio_pwm
//   Self-checking bench for led_pio_pwm. A behavioural model, written with
//   plain integers from the register-map and period rules, pushes the expected
//   LED / irq / readdata values for every clock into a queue; a monitor pops
//   and compares on the falling edge. Directed sequences cover the reset state,
//   static/invert output, duty extremes, interrupt timing and (when compiled
//   with LED_PIO_BLINK_EN) blinking; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_led_pio_pwm;

    localparam int WIDTH    = 8;
    localparam int PWM_BITS = 8;
`ifdef LED_PIO_BLINK_EN
    localparam int BLINK_SHIFT = 1;
`else
    localparam int BLINK_SHIFT = 6;
`endif
    localparam int          CMAX  = 1 << PWM_BITS;
    localparam logic [31:0] WMASK = 32'((64'd1 << WIDTH) - 1);
    localparam logic [31:0] PMASK = 32'((64'd1 << PWM_BITS) - 1);

    logic             clk_clk = 1'b0;
    logic             reset_reset;
    logic [2:0]       avs_address;
    logic             avs_read;
    logic             avs_write;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic [WIDTH-1:0] led_pio_export;
    logic             irq;

    led_pio_pwm #(
        .WIDTH       (WIDTH),
        .PWM_BITS    (PWM_BITS),
        .BLINK_SHIFT (BLINK_SHIFT)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .led_pio_export (led_pio_export),
        .irq            (irq)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        logic [WIDTH-1:0] led;
        logic             irq;
        logic [31:0]      rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_data, m_mode, m_ps, m_sel, m_blink, m_rd;
    int          m_pend [WIDTH];
    int          m_act  [WIDTH];
    bit          m_en, m_inv, m_ien, m_ipend, m_bnd_next;
    int          m_pre, m_cnt, m_bcnt;

    function automatic void model_reset();
        m_data = '0; m_mode = '0; m_ps = '0; m_sel = '0; m_blink = '0; m_rd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
        m_en = 0; m_inv = 0; m_ien = 0; m_ipend = 0; m_bnd_next = 0;
        m_pre = 0; m_cnt = 0; m_bcnt = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v = m_data;
            3'd1: v = m_mode;
            3'd2: v = m_ps;
            3'd3: v = m_sel;
            3'd4: if (m_sel < WIDTH) v = 32'(m_pend[m_sel]);
            3'd5: v = {28'd0, m_ipend, m_ien, m_inv, m_en};
`ifdef LED_PIO_BLINK_EN
            3'd6: v = m_blink;
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: m_data = d & WMASK;
            3'd1: m_mode = d & WMASK;
            3'd2: begin
                m_ps  = d & 32'hFFFF;
                m_pre = 0;
            end
            3'd3: m_sel = d & 32'h1F;
            3'd4: if (m_sel < WIDTH) m_pend[m_sel] = int'(d & PMASK);
            3'd5: begin
                m_en  = d[0];
                m_inv = d[1];
                m_ien = d[2];
                if (d[3]) m_ipend = 0;
            end
`ifdef LED_PIO_BLINK_EN
            3'd6: m_blink = d & WMASK;
`endif
            default: ;
        endcase
    endfunction

    // One model step per rising edge: outputs come from the state before the
    // edge, then the period advances, then software writes apply.
    always @(posedge clk_clk) begin
        exp_t e;
        bit   tick, bnd, lvl;
        if (reset_reset) begin
            model_reset();
            e.led = '0;
            e.irq = 1'b0;
            e.rd  = '0;
        end else begin
            tick = m_en && (m_pre == int'(m_ps));
            bnd  = tick && (m_cnt == CMAX - 1);
            for (int i = 0; i < WIDTH; i++) begin
                lvl = m_mode[i] ? (m_cnt < m_act[i]) : m_data[i];
`ifdef LED_PIO_BLINK_EN
                if (m_blink[i] && (((m_bcnt >> BLINK_SHIFT) % 2) == 0)) lvl = 1'b0;
`endif
                e.led[i] = m_en && (lvl ^ m_inv);
            end
            e.irq = m_ipend && m_ien;
            if (avs_read) m_rd = model_read(avs_address);
            e.rd = m_rd;
            if (!m_en) begin
                m_pre = 0; m_cnt = 0; m_bcnt = 0;
            end else if (tick) begin
                m_pre = 0;
                m_cnt = (m_cnt + 1) % CMAX;
                if (bnd) begin
                    m_bcnt++;
                    m_act = m_pend;
                end
            end else begin
                m_pre++;
            end
            if (avs_write) model_write(avs_address, avs_writedata);
            if (bnd) m_ipend = 1'b1;
            m_bnd_next = m_en && (m_pre == int'(m_ps)) && (m_cnt == CMAX - 1);
        end
        exp_q.push_back(e);
    end

    // -------------------------------------------------------------- monitor
    always @(negedge clk_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led", 32'(led_pio_export), 32'(e.led));
            check("irq", 32'(irq), 32'(e.irq));
            check("readdata", avs_readdata, e.rd);
        end
    end

    // --------------------------------------------------------------- driver
    // Called at a falling edge; drives one bus cycle and returns at the next one.
    task automatic bus(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d);
        avs_read = r; avs_write = w; avs_address = a; avs_writedata = d;
        @(negedge clk_clk);
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Returns at the falling edge just before a period boundary edge.
    task automatic wait_boundary(input string name);
        int k = 0;
        while (!m_bnd_next && k < 5000) begin
            @(negedge clk_clk);
            k++;
        end
        check(name, 32'(m_bnd_next), 32'd1);
    endtask

    task automatic count_high(input int bit_idx, input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            @(negedge clk_clk);
            hi += int'(led_pio_export[bit_idx]);
        end
    endtask

    function automatic logic [31:0] rand_data(input logic [2:0] a);
        logic [31:0] d;
        d = $urandom;
        case (a)
            3'd2: d = $urandom_range(0, 2);
            3'd3: d = $urandom_range(0, 11);
            3'd5: d[0] = ($urandom_range(0, 7) != 0);
            default: ;
        endcase
        return d;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        logic [2:0] a;
        reset_reset = 1'b1;
        avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
        idle(3);
        reset_reset = 1'b0;

        // Reset state: every address reads 0, outputs dark.
        for (int i = 0; i < 8; i++) bus(1'b1, 1'b0, 3'(i), '0);
        check("reset_led", 32'(led_pio_export), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);

        // Static output and inversion, visible one cycle after the write.
        bus(1'b0, 1'b1, 3'd5, 32'h1);
        bus(1'b0, 1'b1, 3'd0, 32'hA5);
        idle(1);
        check("static_a5", 32'(led_pio_export), 32'hA5);
        bus(1'b0, 1'b1, 3'd5, 32'h3);
        idle(1);
        check("invert_5a", 32'(led_pio_export), 32'h5A);
        bus(1'b0, 1'b1, 3'd5, 32'h1);

        // PWM duty 64 on ch0 and 255 on ch1; duty for an absent channel ignored.
        bus(1'b0, 1'b1, 3'd2, 32'h0);
        bus(1'b0, 1'b1, 3'd1, 32'h3);
        bus(1'b0, 1'b1, 3'd3, 32'd0);
        bus(1'b0, 1'b1, 3'd4, 32'd64);
        bus(1'b0, 1'b1, 3'd3, 32'd1);
        bus(1'b0, 1'b1, 3'd4, 32'd255);
        bus(1'b0, 1'b1, 3'd3, 32'd20);
        bus(1'b0, 1'b1, 3'd4, 32'd77);
        bus(1'b1, 1'b0, 3'd4, 32'd0);
        idle(600);
        count_high(0, CMAX, hi);
        check("duty64_high", 32'(hi), 32'd64);
        count_high(1, CMAX, hi);
        check("duty255_high", 32'(hi), 32'd255);
        bus(1'b0, 1'b1, 3'd3, 32'd1);
        bus(1'b0, 1'b1, 3'd4, 32'd0);
        idle(600);
        count_high(1, CMAX, hi);
        check("duty0_high", 32'(hi), 32'd0);

        // Interrupt: clear, rise one cycle after the wrap, set beats clear.
        wait_boundary("bnd_wait_a");
        idle(1);
        bus(1'b0, 1'b1, 3'd5, 32'hD);
        idle(1);
        check("irq_cleared", 32'(irq), 32'd0);
        wait_boundary("bnd_wait_b");
        idle(1);
        check("irq_pre_rise", 32'(irq), 32'd0);
        idle(1);
        check("irq_rise", 32'(irq), 32'd1);
        wait_boundary("bnd_wait_c");
        bus(1'b0, 1'b1, 3'd5, 32'hD);
        idle(1);
        check("irq_set_wins", 32'(irq), 32'd1);

`ifdef LED_PIO_BLINK_EN
        // Blink on static ch2: 512 clocks off, 512 on per 1024.
        bus(1'b0, 1'b1, 3'd0, 32'h4);
        bus(1'b0, 1'b1, 3'd6, 32'h4);
        idle(1100);
        count_high(2, 4 * CMAX, hi);
        check("blink_half", 32'(hi), 32'(2 * CMAX));
`endif

        // Randomized phase.
        repeat (2500) begin
            int op;
            op = $urandom_range(0, 15);
            a  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) begin
                reset_reset = 1'b1;
                idle(1);
                reset_reset = 1'b0;
            end else if (op == 0) begin
                bus(1'b0, 1'b1, a, rand_data(a));
            end else if (op == 1) begin
                bus(1'b1, 1'b0, a, '0);
            end else if (op == 2) begin
                bus(1'b1, 1'b1, a, rand_data(a));
            end else begin
                idle($urandom_range(1, 20));
            end
        end

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pio_pwm.md
# led_pio_pwm

Parametrised successor to the 8-bit LED PIO. It is an Avalon-MM slave on the system interconnect that drives `WIDTH` LED outputs. Each channel is either a static bit or a PWM channel with its own duty register. All channels share a programmable prescaler, and period-boundary duty updates keep the outputs glitch-free. An optional period interrupt and an optional blink mode complete the block.

## Interface
Parameters:
- `WIDTH`, default 8: number of LED channels, 1..32.
- `PWM_BITS`, default 8: PWM counter and duty width, 4..16.
- `BLINK_SHIFT`, default 6: blink toggles every 2^`BLINK_SHIFT` PWM periods. Only used when blink is compiled in.

Ports:
- `clk_clk` in 1: system clock. One clock domain only.
- `reset_reset` in 1: reset, synchronous and active-high.
- `avs_address` in 3: word address.
- `avs_read` in 1: read strobe.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: read data. Fixed read latency of 1 cycle. No waitrequest.
- `led_pio_export` out `WIDTH`: LED outputs.
- `irq` out 1: level interrupt, period wrap.

## Operation
Register map (word addresses); unused bits read 0:
- 0 DATA [`WIDTH`-1:0]: static value for channels in static mode. R/W.
- 1 MODE [`WIDTH`-1:0]: per channel, 0 = static, 1 = PWM. R/W.
- 2 PRESCALE [15:0]: a tick fires every PRESCALE+1 clocks. R/W.
- 3 DUTY_SEL [4:0]: channel index used for DUTY access. R/W.
- 4 DUTY [`PWM_BITS`-1:0]: pending duty of channel DUTY_SEL.
  - If DUTY_SEL ≥ `WIDTH`, writes are ignored and reads return 0.
- 5 CTRL:
  - bit0 ENABLE: when 0, all outputs are 0 and the counters are held at 0.
  - bit1 INVERT: final output XOR.
  - bit2 IRQ_EN.
  - bit3 IRQ_PEND: write 1 to clear. Read returns pending status.
- 6 BLINK [`WIDTH`-1:0]: per-channel blink enable. Exists only with the blink macro defined.

Datapath:
- Prescaler counter `pre` counts 0..PRESCALE, then wraps and asserts `tick` for one cycle.
- PWM counter `cnt` (`PWM_BITS` wide) increments on each `tick` and wraps from 2^`PWM_BITS`-1 to 0.
- Period boundary = the tick on which `cnt` wraps to 0.
  - At the boundary, every channel's pending duty is copied into its active duty register.
  - At the boundary, IRQ_PEND is set.
- Raw channel output:
  - PWM mode: `cnt < active_duty`.
  - Static mode: DATA bit.
- Duty range:
  - Duty 0 means always low.
  - Duty 2^`PWM_BITS`-1 means high for all but one count per period.
- `irq` = IRQ_PEND & IRQ_EN.
- A boundary set and a software clear of IRQ_PEND in the same cycle: the set wins.
- Writing PRESCALE resets `pre` to 0. `cnt` is not reset.

## Timing
- Reset values:
  - All registers 0.
  - `pre`, `cnt` and all duties 0.
  - `led_pio_export` 0, `avs_readdata` 0, `irq` 0.
- Read: `avs_readdata` is valid exactly 1 cycle after `avs_read`. It holds its value until the next read.
- Write: register updates on the clock edge with `avs_write`.
  - `led_pio_export` reflects DATA, MODE, CTRL and BLINK changes 1 cycle later, because the output is registered.
  - DUTY changes reach the output only after the next period boundary, plus 1 cycle.
- Simultaneous read and write to the same address: the read returns the old value.
- Reset mid-period: everything returns to reset values on the next edge, and the PWM restarts at `cnt` = 0.
- Registered outputs: `led_pio_export` and `irq`.

## Configuration
- Macro: `LED_PIO_BLINK_EN`.
- Defined:
  - The BLINK register exists at address 6.
  - A blink phase bit toggles every 2^`BLINK_SHIFT` period boundaries.
  - Channels with their BLINK bit set are forced to 0 while the phase is 0. This gating is applied before INVERT.
  - The phase counter resets to 0, with phase = 1 meaning visible.
- Undefined:
  - No blink logic is synthesised.
  - Address 6 reads 0 and ignores writes.

## Test plan
- Reset, then read all addresses → every value reads 0, `led_pio_export`=0, `irq`=0.
- ENABLE=1, MODE=0, DATA=0xA5 → `led_pio_export`=0xA5 one cycle after the write. Then set INVERT → 0x5A.
- `PWM_BITS`=8, PRESCALE=0, MODE bit0=1, DUTY_SEL=0, DUTY=64 → after the next period boundary, bit0 is high for exactly 64 of every 256 clocks.
- Duty 0 and duty 255 on channel 1 → bit1 is constantly 0, and high 255 of 256 clocks respectively. Changing DUTY mid-period does not alter the current period.
- IRQ_EN=1 → `irq` rises 1 cycle after the wrap. Writing CTRL with bit3=1 clears it. A clear coinciding with a wrap leaves it set.
- With `LED_PIO_BLINK_EN`, BLINK_SHIFT=1, PRESCALE=0, static DATA bit2=1, BLINK bit2=1 → bit2 alternates between 512 clocks off and 512 clocks on.
